// File: rtl/mac_seq.sv
// Sequential multiply-accumulate: streams (w,x) pairs through an external multiplier and sums the products.
// Define MAC_SEQ_SAT_EN to clamp the accumulator at all-ones instead of wrapping on overflow.
module mac_seq #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_w,
    input  logic [7:0]       in_x,
    output logic [7:0]       mul_w,
    output logic [7:0]       mul_x,
    input  logic [15:0]      mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             prod_valid;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic             accept;
    logic             last_accept;
    logic             launch;

    // Acceptance is decoded from the state directly so next-state logic has no loop through in_ready.
    assign accept      = in_valid && (state == RUN);
    assign last_accept = accept && (count == len_q - LEN_W'(1));
    assign launch      = (state == IDLE) && start;
    assign out_acc     = acc;

`ifdef MAC_SEQ_SAT_EN
    localparam int SUM_W = ACC_W + 1;
    logic [SUM_W-1:0] sum_full;

    assign sum_full = {1'b0, acc} + SUM_W'(mul_y);
    assign acc_add  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_add = acc + ACC_W'(mul_y);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (vec_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The product of a pair accepted on one edge is summed on the next, so the DRAIN cycle adds the last one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count      <= '0;
            len_q      <= '0;
            mul_w      <= '0;
            mul_x      <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_valid <= accept;
            if (accept) begin
                mul_w <= in_w;
                mul_x <= in_x;
                count <= count + LEN_W'(1);
            end
            if (launch) begin
                count <= '0;
                len_q <= vec_len;
                acc   <= '0;
            end else if (prod_valid) begin
                acc <= acc_add;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq; a second 16-bit-accumulator instance shares the inputs to exercise overflow.
module tb_mac_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  vec_len;
    logic        in_valid;
    logic [7:0]  in_w;
    logic [7:0]  in_x;
    logic        out_ready;

    logic        busy;
    logic        in_ready;
    logic [7:0]  mul_w;
    logic [7:0]  mul_x;
    logic [15:0] mul_y;
    logic        out_valid;
    logic [23:0] out_acc;

    logic        busyB;
    logic        inReadyB;
    logic [7:0]  mulWB;
    logic [7:0]  mulXB;
    logic [15:0] mulYB;
    logic        outValidB;
    logic [15:0] outAccB;

    int checkCount = 0;
    int passCount  = 0;

    assign mul_y = 16'(mul_w * mul_x);
    assign mulYB = 16'(mulWB * mulXB);

    mac_seq #(.ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .vec_len(vec_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x),
        .mul_w(mul_w), .mul_x(mul_x), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
    );

    mac_seq #(.ACC_W(16), .LEN_W(8)) dutNarrow (
        .clk(clk), .rstn(rstn), .start(start), .vec_len(vec_len), .busy(busyB),
        .in_valid(in_valid), .in_ready(inReadyB), .in_w(in_w), .in_x(in_x),
        .mul_w(mulWB), .mul_x(mulXB), .mul_y(mulYB),
        .out_valid(outValidB), .out_ready(out_ready), .out_acc(outAccB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] w, input logic [7:0] x);
        in_valid = valid;
        in_w     = w;
        in_x     = x;
        tick();
    endtask

    task automatic launch(input logic [7:0] len);
        start   = 1'b1;
        vec_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        in_w      = '0;
        in_x      = '0;
        out_ready = 1'b0;
        tick();
        tick();

        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mul_w", 32'(mul_w), 32'd0);
        checkOutput("rst_mul_x", 32'(mul_x), 32'd0);
        checkOutput("rst_out_acc", 32'(out_acc), 32'd0);
        rstn = 1'b1;
        tick();

        // 16 back-to-back pairs: 4 * (0+1+...+15) = 480
        launch(8'd16);
        checkOutput("s1_busy", 32'(busy), 32'd1);
        checkOutput("s1_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'd4, 8'(i));
        end
        in_valid = 1'b0;
        checkOutput("s1_drain_in_ready", 32'(in_ready), 32'd0);
        checkOutput("s1_drain_out_valid", 32'(out_valid), 32'd0);
        checkOutput("s1_mul_w", 32'(mul_w), 32'd4);
        checkOutput("s1_mul_x", 32'(mul_x), 32'd15);
        tick();
        checkOutput("s1_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s1_out_acc", 32'(out_acc), 32'd480);
        handshake();
        checkOutput("s1_idle_busy", 32'(busy), 32'd0);

        // Zero-length vector goes straight to DONE with a cleared sum
        in_valid = 1'b1;
        launch(8'd0);
        checkOutput("s2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s2_out_acc", 32'(out_acc), 32'd0);
        checkOutput("s2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        handshake();
        checkOutput("s2_idle_busy", 32'(busy), 32'd0);

        // Gapped input; vec_len is altered after start to prove the latched length is used
        launch(8'd4);
        vec_len = 8'd1;
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 0) applyStimulus(1'b1, 8'd255, 8'd255);
            else            applyStimulus(1'b0, 8'd7, 8'd9);
            if (k == 3) begin
                checkOutput("s3_stall_in_ready", 32'(in_ready), 32'd1);
                checkOutput("s3_stall_mul_x", 32'(mul_x), 32'd255);
            end
        end
        in_valid = 1'b0;
        checkOutput("s3_drain_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("s3_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s3_out_acc", 32'(out_acc), 32'd260100);
`ifdef MAC_SEQ_SAT_EN
        checkOutput("s3_narrow_acc", 32'(outAccB), 32'd65535);
`else
        checkOutput("s3_narrow_acc", 32'(outAccB), 32'd63492);
`endif

        // Hold the result with out_ready low; a start pulse in DONE must be ignored
        for (int k = 0; k < 5; k++) begin
            start   = (k == 2);
            vec_len = 8'd3;
            tick();
            checkOutput("s4_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("s4_hold_acc", 32'(out_acc), 32'd260100);
        end
        start = 1'b0;
        handshake();
        checkOutput("s4_idle_busy", 32'(busy), 32'd0);
        checkOutput("s4_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("s4_still_idle", 32'(busy), 32'd0);

        // 255*255 twice: 130050 fits 24 bits, overflows 16 bits
        launch(8'd2);
        applyStimulus(1'b1, 8'd255, 8'd255);
        applyStimulus(1'b1, 8'd255, 8'd255);
        in_valid = 1'b0;
        tick();
        checkOutput("s5_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s5_out_acc", 32'(out_acc), 32'd130050);
`ifdef MAC_SEQ_SAT_EN
        checkOutput("s5_narrow_acc", 32'(outAccB), 32'd65535);
`else
        checkOutput("s5_narrow_acc", 32'(outAccB), 32'd64514);
`endif
        handshake();

        // Reset mid-run after 3 of 8 accepts, then a fresh 2-pair run of 3*5
        launch(8'd8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd1, 8'd1);
        end
        rstn = 1'b0;
        tick();
        checkOutput("s6_rst_busy", 32'(busy), 32'd0);
        checkOutput("s6_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("s6_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("s6_rst_out_acc", 32'(out_acc), 32'd0);
        rstn     = 1'b1;
        in_valid = 1'b0;
        tick();
        launch(8'd2);
        applyStimulus(1'b1, 8'd3, 8'd5);
        applyStimulus(1'b1, 8'd3, 8'd5);
        in_valid = 1'b0;
        tick();
        checkOutput("s6_out_valid", 32'(out_valid), 32'd1);
        checkOutput("s6_out_acc", 32'(out_acc), 32'd30);
        handshake();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
